uart_sample_tx: RTL and testbench
=================================

# uart_sample_tx

UART transmitter for the logic analyzer's output path. It buffers bytes from the capture/decode logic in a small FIFO and serialises them on a single line as 8N1 frames. The default rate is 115200 baud at 100 MHz, the same frame format the analyzer's UART decoder receives, so `tx` can be looped back into the decoder's RX input.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  8  byte to transmit.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  FIFO can accept; a byte is pushed on a rising edge where `din_valid && din_ready`.
- `tx`  out  1  serial output; idles high.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued (0..FIFO_DEPTH).

## Operation
- FIFO:
  - `din_ready` = !full, combinational from registered state.
  - Push when `din_valid && din_ready`.
  - Push and pop on the same edge: both occur and `fifo_level` is unchanged.
  - When full there is no push-through. `din_ready` stays low until a pop, and `din` is ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: `tx`=1. If FIFO is non-empty, pop into shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. 3-bit index 0..7, then STOP (or PARITY, see Configuration).
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At its last cycle, if FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Bit timer:
  - Counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - Reloads to 0 on each bit boundary.
- `tx` is driven from a flop; no combinational glitches.
- Bytes pushed while a frame is in flight are queued. They never alter the frame in progress.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_level`=0, `din_ready`=1, FSM=IDLE, pointers=0, timer=0.
- Reset asserted mid-frame: `tx` goes 1 immediately (asynchronous) and the FIFO contents are discarded. No partial frame resumes after release.
- Latency: a byte pushed on edge N into an empty FIFO while IDLE is popped on edge N+1. `tx` falls and `busy` rises on edge N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles (11· with parity) from the `tx` falling edge to the end of stop.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop cycle.
- `fifo_level` decrements on the pop edge. This is the START entry, not frame completion.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It sends one bit, CLKS_PER_BIT long, equal to the even parity (XOR) of the 8 data bits.
  - Frame is 8E1, 11 bits.
- Macro undefined: no PARITY state and no parity logic; frame is 8N1, 10 bits.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated.

- Single byte 0xA5, sampled at mid-bit -> `tx` = 0,1,0,1,0,0,1,0,1,1. `busy` high for exactly 40 cycles. `tx` falls 1 cycle after the push edge.
- Hold `din_valid` for 6 bytes 0x01..0x06 while idle:
  - `din_ready` drops when `fifo_level` reaches 4.
  - 0x06 is accepted only after a pop.
  - All 6 frames go out in order with zero idle cycles between stop and start.
- Push while frame 1 is mid-DATA -> frame 1 is unchanged. Frame 2 (0x3C) starts immediately after stop. Push and pop on the same edge keep `fifo_level` constant.
- Assert `rst_n`=0 during bit 3 of 0xFF with 2 bytes queued:
  - `tx`=1 asynchronously and `fifo_level`=0.
  - After release, `tx` stays 1 and `busy`=0 with no further frames.
- Loopback at CLKS_PER_BIT=868 into the analyzer's UART decoder (mode 010): send 0xA5 -> decoder outputs 0xA5. Repeat for 0x00 and 0xFF.
- With `UART_TX_PARITY_EN`: 0xA5 -> parity bit 0, frame 44 cycles. 0x07 -> parity bit 1.

Source files
------------

// File: rtl/uart_sample_tx.sv
// uart_sample_tx: FIFO-buffered 8N1 UART transmitter for the analyzer output.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_sample_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [LW-1:0] count;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tx_q;

  logic full;
  logic empty;
  logic bit_end;
  logic push;
  logic pop;

  assign full    = (count == L_FULL);
  assign empty   = (count == '0);
  assign bit_end = (timer == T_LAST);
  assign push    = din_valid && !full;
  assign pop     = !empty &&
                   ((state == S_IDLE) ||
                    ((state == S_STOP) && bit_end));

  assign din_ready  = !full;
  assign busy       = (state != S_IDLE);
  assign fifo_level = count;
  assign tx         = tx_q;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; tx is registered so the line never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else if (pop) begin
      shreg <= mem[rptr];
      state <= S_START;
      timer <= '0;
      tx_q  <= 1'b0;
    end else if (state != S_IDLE) begin
      if (!bit_end) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
        unique case (1'b1)
          (state == S_START): begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx_q    <= shreg[0];
          end
          (state == S_DATA): begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_q  <= ^shreg;
`else
              state <= S_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[bit_idx + 3'd1];
            end
          end
`ifdef UART_TX_PARITY_EN
          (state == S_PARITY): begin
            state <= S_STOP;
            tx_q  <= 1'b1;
          end
`endif
          (state == S_STOP): begin
            state <= S_IDLE;
            tx_q  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            tx_q  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_tx.sv
// tb_uart_sample_tx: directed + random bench for uart_sample_tx.
// Reference is a byte queue plus remaining-frame-cycles counter.
module tb_uart_sample_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  int         rem = 0;
  logic [7:0] cur = '0;
  logic       push_m = 1'b0;

  uart_sample_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .tx(tx),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_tx();
    if (rem == 0) return 1'b1;
    return frame_bit(cur, (FRAME - rem) / CPB);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // one clock: advance the model on the edge, compare on the falling edge
  task automatic step();
    logic ready_m;
    logic pop_m;
    @(posedge clk);
    push_m = 1'b0;
    if (!rst_n) begin
      q.delete();
      rem = 0;
    end else begin
      ready_m = (q.size() < DEPTH);
      pop_m   = (q.size() > 0) && (rem <= 1);
      push_m  = din_valid && ready_m;
      if (pop_m) begin
        cur = q.pop_front();
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (push_m) q.push_back(din);
    end
    @(negedge clk);
    check("tx", 32'(tx), 32'(exp_tx()));
    check("busy", 32'(busy), 32'(rem > 0));
    check("level", 32'(fifo_level), 32'(q.size()));
    check("ready", 32'(din_ready), 32'(q.size() < DEPTH));
  endtask

  int a5_bits[11];
  int got[11];
  int busy_cnt;
  int idx;

  initial begin
`ifdef UART_TX_PARITY_EN
    a5_bits = '{0,1,0,1,0,0,1,0,1,0,1};
`else
    a5_bits = '{0,1,0,1,0,0,1,0,1,1,1};
`endif
    // reset
    step();
    step();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // single 0xA5
    din = 8'hA5;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (i == 0) check("a5_fall", 32'(tx), 32'd0);
      if (busy) busy_cnt++;
      if (i % CPB == CPB / 2) got[i / CPB] = int'(tx);
    end
    for (int k = 0; k < NBITS; k++)
      check($sformatf("a5_bit%0d", k), 32'(got[k]), 32'(a5_bits[k]));
    check("a5_busy_len", 32'(busy_cnt), 32'(FRAME));
    step();
    check("a5_idle", 32'(busy), 32'd0);

    // hold valid for 0x01..0x06
    idx = 1;
    din = 8'h01;
    din_valid = 1'b1;
    for (int c = 0; c < 400 && idx <= 6; c++) begin
      step();
      if (push_m) begin
        idx++;
        din = 8'(idx);
      end
    end
    check("burst_accepted", 32'(idx), 32'd7);
    din_valid = 1'b0;
    for (int c = 0; c < 6 * FRAME + 10; c++) step();
    check("burst_drained", 32'(busy), 32'd0);

    // push 0x3C while 0x5A is mid-DATA
    din = 8'h5A;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 3 * CPB; c++) step();
    din = 8'h3C;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 2 * FRAME + 5; c++) step();

    // reset during bit 3 of 0xFF with two bytes queued
    din_valid = 1'b1;
    din = 8'hFF;
    step();
    din = 8'hAA;
    step();
    din = 8'hBB;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 4 * CPB + 1; c++) step();
    check("pre_rst_level", 32'(fifo_level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) step();
    check("post_rst_busy", 32'(busy), 32'd0);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      din = 8'($urandom);
      din_valid = ($urandom_range(0, 3) == 0);
      step();
    end
    din_valid = 1'b0;
    for (int c = 0; c < (DEPTH + 2) * FRAME; c++) step();
    check("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
